// File: rtl/ad9833_sweep_pkg.sv
// Shared types and constants for the AD9833 frequency sweep sequencer.
// Holds the FSM state set, control-word constants and datapath widths.
package ad9833_sweep_pkg;

    localparam int unsigned FREQ_W  = 28;
    localparam int unsigned STEP_W  = 12;
    localparam int unsigned DWELL_W = 24;

    localparam logic [15:0] CTRL_B28    = 16'h2000;
    localparam logic [15:0] CTRL_STOP   = 16'h2100;
    localparam logic [15:0] WAVE_SINE   = 16'h0000;
    localparam logic [15:0] WAVE_TRI    = 16'h0002;
    localparam logic [15:0] WAVE_SQUARE = 16'h0028;
    localparam logic [15:0] WAVE_SQ_DIV = 16'h0020;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DWELL,
        S_STOP_REQ,
        S_STOP_ACK,
        S_STOP_DONE,
        S_FINISH
    } sweep_state_e;

    function automatic logic [15:0] wave_ctrl(input logic [1:0] sel);
        logic [15:0] code;
        code = WAVE_SINE;
        case (sel)
            2'd0:    code = WAVE_SINE;
            2'd1:    code = WAVE_TRI;
            2'd2:    code = WAVE_SQUARE;
            default: code = WAVE_SQ_DIV;
        endcase
        return CTRL_B28 | code;
    endfunction

endpackage

// File: rtl/ad9833_dwell_timer.sv
// Down-counter that holds each sweep point for a loaded number of cycles.
// expire is asserted during the last counted cycle.
module ad9833_dwell_timer
    import ad9833_sweep_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               count,
    output logic               expire
);

    logic [DWELL_W-1:0] count_d;
    logic [DWELL_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    assign expire = count && (count_q == DWELL_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ad9833_sweep.sv
// Sweep sequencer: issues a series of tuning-word writes to an AD9833 serial
// writer, dwelling between points, with optional output-reset stop write.
module ad9833_sweep
    import ad9833_sweep_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  start_word,
    input  logic [FREQ_W-1:0]  step_word,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic [1:0]         wave_sel,
    input  logic               hold_last,
    output logic               go,
    output logic [15:0]        control,
    output logic [FREQ_W-1:0]  freq,
    input  logic               good_to_reset_go,
    input  logic               send_complete,
    output logic               busy,
    output logic               done,
    output logic [STEP_W-1:0]  step_idx,
    output logic               wrapped
);

    sweep_state_e       state_d, state_q;
    logic               go_d, go_q;
    logic [15:0]        control_d, control_q;
    logic [FREQ_W-1:0]  freq_d, freq_q;
    logic               busy_d, busy_q;
    logic               done_d, done_q;
    logic [STEP_W-1:0]  step_idx_d, step_idx_q;
    logic               wrapped_d, wrapped_q;
    logic [FREQ_W-1:0]  step_word_d, step_word_q;
    logic [STEP_W-1:0]  num_steps_d, num_steps_q;
    logic [DWELL_W-1:0] dwell_d, dwell_q;
    logic               hold_last_d, hold_last_q;
    logic               abort_pend_d, abort_pend_q;

    logic               timer_load;
    logic               timer_count;
    logic               timer_expire;
    logic               advance;
    logic [FREQ_W:0]    freq_sum;

    ad9833_dwell_timer u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (dwell_q),
        .count    (timer_count),
        .expire   (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        go_d         = go_q;
        control_d    = control_q;
        freq_d       = freq_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        step_idx_d   = step_idx_q;
        wrapped_d    = wrapped_q;
        step_word_d  = step_word_q;
        num_steps_d  = num_steps_q;
        dwell_d      = dwell_q;
        hold_last_d  = hold_last_q;
        abort_pend_d = abort_pend_q;
        timer_load   = 1'b0;
        timer_count  = 1'b0;
        advance      = 1'b0;
        freq_sum     = {1'b0, freq_q} + {1'b0, step_word_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    step_word_d  = step_word;
                    num_steps_d  = num_steps;
                    dwell_d      = dwell_cycles;
                    hold_last_d  = hold_last;
                    control_d    = wave_ctrl(wave_sel);
                    freq_d       = start_word;
                    step_idx_d   = '0;
                    wrapped_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_d = S_STOP_REQ;
                end else if (!good_to_reset_go) begin
                    go_d    = 1'b1;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (good_to_reset_go) begin
                    go_d    = 1'b0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                // An abort seen during the write (even this cycle) skips the dwell.
                if (send_complete) begin
                    if (abort_pend_q || abort) begin
                        state_d = S_STOP_REQ;
                    end else if (dwell_q != '0) begin
                        timer_load = 1'b1;
                        state_d    = S_DWELL;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                timer_count = 1'b1;
                if (abort) begin
                    state_d = S_STOP_REQ;
                end else if (timer_expire) begin
                    advance = 1'b1;
                end
            end
            S_STOP_REQ: begin
                control_d = CTRL_STOP;
                if (!good_to_reset_go) begin
                    go_d    = 1'b1;
                    state_d = S_STOP_ACK;
                end
            end
            S_STOP_ACK: begin
                if (good_to_reset_go) begin
                    go_d    = 1'b0;
                    state_d = S_STOP_DONE;
                end
            end
            S_STOP_DONE: begin
                if (send_complete) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (step_idx_q == num_steps_q) begin
                state_d = hold_last_q ? S_FINISH : S_STOP_REQ;
            end else begin
                freq_d     = freq_sum[FREQ_W-1:0];
                wrapped_d  = wrapped_q | freq_sum[FREQ_W];
                step_idx_d = step_idx_q + STEP_W'(1);
                state_d    = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            go_q         <= 1'b0;
            control_q    <= CTRL_B28;
            freq_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            step_idx_q   <= '0;
            wrapped_q    <= 1'b0;
            step_word_q  <= '0;
            num_steps_q  <= '0;
            dwell_q      <= '0;
            hold_last_q  <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            control_q    <= control_d;
            freq_q       <= freq_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            step_idx_q   <= step_idx_d;
            wrapped_q    <= wrapped_d;
            step_word_q  <= step_word_d;
            num_steps_q  <= num_steps_d;
            dwell_q      <= dwell_d;
            hold_last_q  <= hold_last_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign go       = go_q;
    assign control  = control_q;
    assign freq     = freq_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;
    assign wrapped  = wrapped_q;

endmodule

// File: doc/ad9833_sweep.md
AD9833_SWEEP -- requirements
Module: ad9833_sweep

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be:
  clk  in  1  system clock
  rst_n  in  1  synchronous active-low reset
  start  in  1  one-cycle sweep request
  abort  in  1  one-cycle stop request
  start_word  in  28  first frequency tuning word
  step_word  in  28  per-point increment
  num_steps  in  12  increments after first point
  dwell_cycles  in  24  clk cycles held per point
  wave_sel  in  2  0 sine, 1 triangle, 2 square, 3 square/2
  hold_last  in  1  1 leaves last tone on, 0 issues output-reset write
  go  out  1  request to serial writer
  control  out  16  control word to serial writer
  freq  out  28  tuning word to serial writer
  good_to_reset_go  in  1  writer has accepted go
  send_complete  in  1  writer one-cycle done pulse
  busy  out  1  sweep in progress
  done  out  1  one-cycle sweep-finished pulse
  step_idx  out  12  index of point being written or dwelt
  wrapped  out  1  sticky, set when freq wraps mod 2^28

Function
REQ-003 Control SHALL be 16'h2000 (B28) OR'd with the waveform code: sine 16'h0000, triangle 16'h0002, square 16'h0028, square/2 16'h0020; the stop write SHALL use 16'h2100.
REQ-004 States SHALL be IDLE, REQ, WAIT_ACK, WAIT_DONE, DWELL, STOP_REQ, STOP_ACK, STOP_DONE, FINISH.
REQ-005 In IDLE, start SHALL latch all configuration inputs, set freq=start_word, step_idx=0, clear wrapped, assert busy and enter REQ on the next cycle.
REQ-006 start while busy SHALL be ignored.
REQ-007 REQ SHALL assert go only when good_to_reset_go is low (rejects the writer's stale ack), then enter WAIT_ACK.
REQ-008 go SHALL stay high until good_to_reset_go is sampled high, and SHALL be low on the following cycle.
REQ-009 control and freq SHALL be stable from go rise until send_complete.
REQ-010 WAIT_DONE SHALL exit on send_complete: to DWELL if dwell_cycles>0, otherwise directly to the next-point decision.
REQ-011 DWELL SHALL last exactly dwell_cycles clk cycles after the send_complete cycle.
REQ-012 Next-point decision: if step_idx==num_steps, go to STOP_REQ when hold_last=0, else FINISH; otherwise freq<=freq+step_word mod 2^28, step_idx+1, then REQ.
REQ-013 A carry out of bit 27 SHALL set wrapped, which holds until the next accepted start.
REQ-014 num_steps=0 SHALL produce exactly one frequency write; total writes SHALL be num_steps+1 (+1 stop write if hold_last=0).
REQ-015 abort during REQ/DWELL SHALL go straight to stop handling.
REQ-016 abort during WAIT_ACK/WAIT_DONE SHALL let the in-flight write finish, then go to stop handling.
REQ-017 abort in IDLE SHALL be ignored.
REQ-018 STOP_REQ/STOP_ACK/STOP_DONE SHALL follow the REQ-007..009 handshake with control=16'h2100, freq unchanged.
REQ-019 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.

Reset
REQ-020 When rst_n is low at a clk edge: state=IDLE, go=0, busy=0, done=0, wrapped=0, step_idx=0, freq=0, control=16'h2000.
REQ-021 Reset mid-sweep SHALL take effect on that edge, abandoning the sweep without a stop write.

Structure
REQ-022 A shared package SHALL hold the state enum, the waveform and control constants (16'h2000, 16'h2100, waveform codes) and the width parameters (28, 12, 24).
REQ-023 The dwell timer SHALL be one sub-module, ad9833_dwell_timer (load, count, expire).

Verification
REQ-024 The bench SHALL cover these scenarios, with the serial writer model at CLKS_PER_BIT=8:
  - start_word=1000, step_word=500, num_steps=3, dwell=20, hold_last=1 -> writes 1000, 1500, 2000, 2500; 20 cycles between each send_complete and next go; one done pulse.
  - num_steps=0, hold_last=0 -> one write of 1000 then one 16'h2100 write; done.
  - start_word=28'hFFFFF00, step_word=28'h200, num_steps=1 -> second write 28'h0000100; wrapped=1.
  - abort mid-WAIT_DONE on point 2 -> point 2 completes, stop write follows, no point 3.
  - rst_n low during DWELL -> go=0 and busy=0 next cycle; start after writer idles works.
  - dwell=0, back-to-back points -> no go assertion while good_to_reset_go is still high from the previous write.
